// File: rtl/pc_stack_if.sv
// Control/status bundle between the decoder (master) and the PC/return-stack block (slave).
// Status signals are all registered inside the slave.
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) ();
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             load;
    logic             inc;
    logic             call;
    logic             ret;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    modport master (
        output in, load, inc, call, ret, clr,
        input  out, depth, empty, full, ovf, udf
    );

    modport slave (
        input  in, load, inc, call, ret, clr,
        output out, depth, empty, full, ovf, udf
    );
endinterface

// File: rtl/pc_stack.sv
// Program counter with hold/load/inc and call/ret through a DEPTH-entry return stack.
// One action per edge, 1-cycle latency, no backpressure; over/underflow set sticky flags.
module pc_stack #(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic        clk,
    input logic        rst_n,
    pc_stack_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic [DW-1:0]    cnt;
    logic [DW-1:0]    cnt_m1;
    logic             empty_r;
    logic             full_r;
    logic             ovf_r;
    logic             udf_r;
    logic             push;

    assign pc_plus1 = pc + WIDTH'(1);
    assign cnt_m1   = cnt - DW'(1);
    // Only a call that actually executes writes the stack: it must win priority and find room.
    assign push     = !bus.clr && !bus.ret && bus.call && !full_r;

    // Storage is deliberately unreset; entries at or above cnt are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[cnt[AW-1:0]] <= pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            cnt     <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else if (bus.clr) begin
            pc      <= RESET_VECTOR;
            cnt     <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else if (bus.ret) begin
            if (!empty_r) begin
                pc      <= stack[cnt_m1[AW-1:0]];
                cnt     <= cnt_m1;
                empty_r <= (cnt == DW'(1));
                full_r  <= 1'b0;
            end else begin
                udf_r   <= 1'b1;
            end
        end else if (bus.call) begin
            if (!full_r) begin
                pc      <= bus.in;
                cnt     <= cnt + DW'(1);
                empty_r <= 1'b0;
                full_r  <= (cnt == DW'(DEPTH - 1));
            end else begin
                ovf_r   <= 1'b1;
            end
        end else if (bus.load) begin
            pc <= bus.in;
        end else if (bus.inc) begin
            pc <= pc_plus1;
        end
    end

    assign bus.out   = pc;
    assign bus.depth = cnt;
    assign bus.empty = empty_r;
    assign bus.full  = full_r;
    assign bus.ovf   = ovf_r;
    assign bus.udf   = udf_r;
endmodule

// File: tb/tb_pc_stack.sv
// Directed and random checks of pc_stack with WIDTH=16, DEPTH=8, RESET_VECTOR=0.
module tb_pc_stack;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nmiss;

    pc_stack_if #(.WIDTH(16), .DEPTH(8)) bus ();

    pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_VECTOR(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model for the random phase
    logic [15:0] m_pc;
    logic [15:0] m_stk [8];
    int          m_d;
    logic        m_ovf;
    logic        m_udf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_dut();
        return 32'({bus.depth, bus.empty, bus.full, bus.ovf, bus.udf});
    endfunction

    function automatic logic [31:0] stat_exp(input int d, input logic o, input logic u);
        logic [3:0] dd;
        dd = 4'(d);
        return 32'({dd, d == 0, d == 8, o, u});
    endfunction

    // drive one cycle of controls, then sample 1 time unit after the edge
    task automatic step(input bit c, input bit r, input bit ca, input bit l, input bit i,
                        input logic [15:0] d);
        bus.clr  = c;
        bus.ret  = r;
        bus.call = ca;
        bus.load = l;
        bus.inc  = i;
        bus.in   = d;
        @(posedge clk);
        #1;
        bus.clr = 0; bus.ret = 0; bus.call = 0; bus.load = 0; bus.inc = 0;
    endtask

    task automatic model_step(input bit c, input bit r, input bit ca, input bit l, input bit i,
                              input logic [15:0] d);
        if (c) begin
            m_pc = 16'h0000; m_d = 0; m_ovf = 0; m_udf = 0;
        end else if (r) begin
            if (m_d > 0) begin
                m_d  = m_d - 1;
                m_pc = m_stk[m_d];
            end else m_udf = 1;
        end else if (ca) begin
            if (m_d < 8) begin
                m_stk[m_d] = m_pc + 16'h0001;
                m_d  = m_d + 1;
                m_pc = d;
            end else m_ovf = 1;
        end else if (l) m_pc = d;
        else if (i) m_pc = m_pc + 16'h0001;
    endtask

    initial begin
        nvec = 0;
        nmiss = 0;
        bus.clr = 0; bus.ret = 0; bus.call = 0; bus.load = 0; bus.inc = 0; bus.in = '0;
        rst_n = 1'b0;
        #13;
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_stat", stat_dut(), stat_exp(0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset / inc / wrap
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 1, 16'h0);
            chk("inc", 32'(bus.out), 32'(k));
        end
        step(0, 0, 0, 1, 0, 16'hFFFF);
        chk("load_ffff", 32'(bus.out), 32'hFFFF);
        step(0, 0, 0, 0, 1, 16'h0);
        chk("inc_wrap", 32'(bus.out), 32'h0000);
        chk("wrap_stat", stat_dut(), stat_exp(0, 0, 0));

        // call/return nesting
        step(0, 0, 0, 1, 0, 16'h0010);
        step(0, 0, 1, 0, 0, 16'h0100);
        chk("call1_out", 32'(bus.out), 32'h0100);
        chk("call1_stat", stat_dut(), stat_exp(1, 0, 0));
        step(0, 0, 1, 0, 0, 16'h0200);
        chk("call2_out", 32'(bus.out), 32'h0200);
        chk("call2_stat", stat_dut(), stat_exp(2, 0, 0));
        step(0, 1, 0, 0, 0, 16'h0);
        chk("ret1_out", 32'(bus.out), 32'h0101);
        step(0, 1, 0, 0, 0, 16'h0);
        chk("ret2_out", 32'(bus.out), 32'h0011);
        chk("ret2_stat", stat_dut(), stat_exp(0, 0, 0));

        // overflow: 8 calls from 0x0011, targets 0x1000,0x1010,...,0x1070
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 1, 0, 0, 16'h1000 + 16'(k * 16));
        end
        chk("full_out", 32'(bus.out), 32'h1070);
        chk("full_stat", stat_dut(), stat_exp(8, 0, 0));
        step(0, 0, 1, 0, 0, 16'hBEEF);
        chk("ovf_out", 32'(bus.out), 32'h1070);
        chk("ovf_stat", stat_dut(), stat_exp(8, 1, 0));
        for (int k = 0; k < 7; k++) begin
            step(0, 1, 0, 0, 0, 16'h0);
            chk("unwind", 32'(bus.out), 32'(16'h1061 - 16'(k * 16)));
        end
        step(0, 1, 0, 0, 0, 16'h0);
        chk("unwind_last", 32'(bus.out), 32'h0012);
        chk("unwind_stat", stat_dut(), stat_exp(0, 1, 0));

        // underflow and clr
        step(0, 1, 0, 0, 0, 16'h0);
        chk("udf_out", 32'(bus.out), 32'h0012);
        chk("udf_stat", stat_dut(), stat_exp(0, 1, 1));
        step(1, 0, 0, 0, 0, 16'h0);
        chk("clr_out", 32'(bus.out), 32'h0000);
        chk("clr_stat", stat_dut(), stat_exp(0, 0, 0));

        // priority
        step(0, 0, 0, 1, 0, 16'h0020);
        step(0, 0, 1, 0, 0, 16'h0300);
        step(0, 1, 1, 1, 1, 16'h0444);
        chk("prio_ret_out", 32'(bus.out), 32'h0021);
        chk("prio_ret_stat", stat_dut(), stat_exp(0, 0, 0));
        step(0, 0, 1, 1, 0, 16'h0500);
        chk("prio_call_out", 32'(bus.out), 32'h0500);
        chk("prio_call_stat", stat_dut(), stat_exp(1, 0, 0));
        step(1, 1, 1, 1, 1, 16'h0666);
        chk("prio_clr_out", 32'(bus.out), 32'h0000);
        chk("prio_clr_stat", stat_dut(), stat_exp(0, 0, 0));

        // call at all-ones pushes 0
        step(0, 0, 0, 1, 0, 16'hFFFF);
        step(0, 0, 1, 0, 0, 16'h0001);
        step(0, 1, 0, 0, 0, 16'h0);
        chk("ret_wrap", 32'(bus.out), 32'h0000);

        // random scoreboard with one async reset pulse
        step(1, 0, 0, 0, 0, 16'h0);
        m_pc = 16'h0; m_d = 0; m_ovf = 0; m_udf = 0;
        for (int n = 0; n < 1000; n++) begin
            bit rc, rr, rca, rl, ri;
            logic [15:0] rd;
            rc  = ($urandom_range(0, 99) < 3);
            rr  = ($urandom_range(0, 99) < 30);
            rca = ($urandom_range(0, 99) < 35);
            rl  = ($urandom_range(0, 99) < 15);
            ri  = ($urandom_range(0, 99) < 50);
            rd  = 16'($urandom);
            model_step(rc, rr, rca, rl, ri, rd);
            step(rc, rr, rca, rl, ri, rd);
            chk("rnd_out", 32'(bus.out), 32'(m_pc));
            chk("rnd_stat", stat_dut(), stat_exp(m_d, m_ovf, m_udf));
            if (n == 500) begin
                bus.call = 1; bus.in = 16'h7777;
                #2;
                rst_n = 1'b0;
                #1;
                chk("arst_out", 32'(bus.out), 32'h0);
                chk("arst_stat", stat_dut(), stat_exp(0, 0, 0));
                @(posedge clk); #1;
                chk("arst_hold", 32'(bus.out), 32'h0);
                bus.call = 0;
                rst_n = 1'b1;
                m_pc = 16'h0; m_d = 0; m_ovf = 0; m_udf = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
